// File: rtl/per2axi_b_resp_collector.sv
// per2axi_b_resp_collector: AXI B-channel consumer that counts outstanding writes and buffers responses in a FIFO.
// Optional macro PER2AXI_B_BYPASS_EN forwards a response with zero latency when the FIFO is empty.
module per2axi_b_resp_collector #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned USER_WIDTH      = 6,
  parameter int unsigned BUFFER_DEPTH    = 2,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  aw_issued_i,
  output logic                  outstanding_full_o,
  input  logic                  axi_b_valid_i,
  input  logic [1:0]            axi_b_resp_i,
  input  logic [ID_WIDTH-1:0]   axi_b_id_i,
  input  logic [USER_WIDTH-1:0] axi_b_user_i,
  output logic                  axi_b_ready_o,
  output logic                  per_r_valid_o,
  output logic                  per_r_opc_o,
  output logic [ID_WIDTH-1:0]   per_r_id_o,
  output logic [USER_WIDTH-1:0] per_r_user_o,
  input  logic                  per_r_ready_i,
  output logic                  err_unexpected_o
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW = ID_WIDTH + USER_WIDTH + 1;

  logic [EW-1:0] mem_q [BUFFER_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          fifo_empty, fifo_full, cnt_full, cnt_zero;
  logic          b_accept, b_expected, bypass, push, pop;
  logic [EW-1:0] b_entry, head, out_data;
  logic          unused_resp_lsb;

  assign unused_resp_lsb = axi_b_resp_i[0];

  // Pointers carry a wrap bit so full and empty are distinguishable
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cnt_full   = (cnt_q == CW'(MAX_OUTSTANDING));
  assign cnt_zero   = (cnt_q == '0);

  assign b_entry    = {axi_b_resp_i[1], axi_b_id_i, axi_b_user_i};
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign axi_b_ready_o      = rst_ni & ~fifo_full;
  assign outstanding_full_o = rst_ni & cnt_full;
  assign err_unexpected_o   = rst_ni & err_q;

  assign b_accept   = axi_b_valid_i & axi_b_ready_o;
  assign b_expected = b_accept & ~cnt_zero;

`ifdef PER2AXI_B_BYPASS_EN
  assign bypass        = b_expected & fifo_empty & per_r_ready_i;
  assign per_r_valid_o = rst_ni & (~fifo_empty | b_expected);
`else
  assign bypass        = 1'b0;
  assign per_r_valid_o = rst_ni & ~fifo_empty;
`endif

  assign push = b_expected & ~bypass;
  assign pop  = rst_ni & ~fifo_empty & per_r_ready_i;

  // Head entry when buffered, incoming beat only on the bypass path, zero otherwise
  always_comb begin
    out_data = '0;
    if (per_r_valid_o) begin
      out_data = fifo_empty ? b_entry : head;
    end
  end

  assign {per_r_opc_o, per_r_id_o, per_r_user_o} = out_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
    err_d    = err_q | (b_accept & cnt_zero);
    cnt_d    = cnt_q;
    if (aw_issued_i && !b_expected) begin
      if (!cnt_full) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (b_expected && !aw_issued_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= b_entry;
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(aw_issued_i && cnt_full && !b_expected))
    else $error("aw_issued_i while outstanding counter is at its limit");
`endif

endmodule

// File: tb/tb_per2axi_b_resp_collector.sv
// Bench for per2axi_b_resp_collector: directed scenarios plus a randomized run against a queue-based model.
module tb_per2axi_b_resp_collector;

  localparam int unsigned IDW   = 4;
  localparam int unsigned UW    = 6;
  localparam int unsigned DEPTH = 2;
  localparam int          MAXO  = 8;
`ifdef PER2AXI_B_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           aw_issued_i;
  logic           outstanding_full_o;
  logic           axi_b_valid_i;
  logic [1:0]     axi_b_resp_i;
  logic [IDW-1:0] axi_b_id_i;
  logic [UW-1:0]  axi_b_user_i;
  logic           axi_b_ready_o;
  logic           per_r_valid_o;
  logic           per_r_opc_o;
  logic [IDW-1:0] per_r_id_o;
  logic [UW-1:0]  per_r_user_o;
  logic           per_r_ready_i;
  logic           err_unexpected_o;

  int errors = 0;
  int checks = 0;

  per2axi_b_resp_collector #(
    .ID_WIDTH(IDW), .USER_WIDTH(UW), .BUFFER_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .aw_issued_i       (aw_issued_i),
    .outstanding_full_o(outstanding_full_o),
    .axi_b_valid_i     (axi_b_valid_i),
    .axi_b_resp_i      (axi_b_resp_i),
    .axi_b_id_i        (axi_b_id_i),
    .axi_b_user_i      (axi_b_user_i),
    .axi_b_ready_o     (axi_b_ready_o),
    .per_r_valid_o     (per_r_valid_o),
    .per_r_opc_o       (per_r_opc_o),
    .per_r_id_o        (per_r_id_o),
    .per_r_user_o      (per_r_user_o),
    .per_r_ready_i     (per_r_ready_i),
    .err_unexpected_o  (err_unexpected_o)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending acks, an outstanding count and a sticky error flag
  logic [10:0] mq[$];
  int          mcnt = 0;
  bit          merr = 1'b0;
  bit          m_acc, m_exp, m_fwd;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
      merr = 1'b0;
    end else begin
      m_acc = axi_b_valid_i && (mq.size() < int'(DEPTH));
      m_exp = m_acc && (mcnt > 0);
      m_fwd = BYP && m_exp && (mq.size() == 0) && per_r_ready_i;
      if (mq.size() > 0 && per_r_ready_i) void'(mq.pop_front());
      if (m_exp && !m_fwd) mq.push_back({axi_b_resp_i[1], axi_b_id_i, axi_b_user_i});
      if (m_acc && mcnt == 0) merr = 1'b1;
      if (aw_issued_i && !m_exp) begin
        if (mcnt < MAXO) mcnt++;
      end else if (m_exp && !aw_issued_i) begin
        mcnt--;
      end
    end
  end

  // Expected {valid, b_ready, full, err, opc, id, user} for the current inputs
  function automatic logic [14:0] exp_out();
    logic        br, ex, v;
    logic [10:0] d;
    if (!rst_n) return 15'h0;
    br = (mq.size() < int'(DEPTH));
    ex = axi_b_valid_i && br && (mcnt > 0);
    v  = (mq.size() > 0) || (BYP && ex);
    d  = 11'h0;
    if (mq.size() > 0) d = mq[0];
    else if (v)        d = {axi_b_resp_i[1], axi_b_id_i, axi_b_user_i};
    return {v, br, (mcnt == MAXO), merr, d};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic aw, input logic bv, input logic [1:0] r,
                        input logic [IDW-1:0] i, input logic [UW-1:0] u, input logic rdy);
    aw_issued_i   = aw;
    axi_b_valid_i = bv;
    axi_b_resp_i  = r;
    axi_b_id_i    = i;
    axi_b_user_i  = u;
    per_r_ready_i = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 2'b00, 0, 0, 0);
    adv(); adv();
    @(negedge clk);
    checks++; if (per_r_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", per_r_valid_o); end
    checks++; if (axi_b_ready_o !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b exp 0", axi_b_ready_o); end
    checks++; if (outstanding_full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", outstanding_full_o); end
    checks++; if (err_unexpected_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err_unexpected_o); end
    checks++; if ({per_r_opc_o, per_r_id_o, per_r_user_o} !== 11'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", {per_r_opc_o, per_r_id_o, per_r_user_o}); end
    adv();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (axi_b_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_b_ready: got %b exp 1", axi_b_ready_o); end
    checks++; if (per_r_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b exp 0", per_r_valid_o); end
    adv();
  endtask

  task automatic test_basic();
    logic [10:0] e;
    set_in(1, 0, 2'b00, 0, 0, 1);
    adv(); adv(); adv();
    set_in(0, 1, 2'b00, 4'd5, 6'h2a, 1);
    @(negedge clk);
    checks++; if (axi_b_ready_o !== 1'b1) begin errors++; $display("FAIL basic_b_ready: got %b exp 1", axi_b_ready_o); end
    checks++; if (per_r_valid_o !== BYP) begin errors++; $display("FAIL basic_valid_c0: got %b exp %b", per_r_valid_o, BYP); end
    e = BYP ? {1'b0, 4'd5, 6'h2a} : 11'h0;
    checks++; if ({per_r_opc_o, per_r_id_o, per_r_user_o} !== e) begin errors++; $display("FAIL basic_data_c0: got %h exp %h", {per_r_opc_o, per_r_id_o, per_r_user_o}, e); end
    adv();
    set_in(0, 0, 2'b00, 0, 0, 1);
    @(negedge clk);
    checks++; if (per_r_valid_o !== !BYP) begin errors++; $display("FAIL basic_valid_c1: got %b exp %b", per_r_valid_o, !BYP); end
    e = BYP ? 11'h0 : {1'b0, 4'd5, 6'h2a};
    checks++; if ({per_r_opc_o, per_r_id_o, per_r_user_o} !== e) begin errors++; $display("FAIL basic_data_c1: got %h exp %h", {per_r_opc_o, per_r_id_o, per_r_user_o}, e); end
    adv();
  endtask

  task automatic test_buffered();
    logic [10:0] e;
    set_in(0, 1, 2'b10, 4'd1, 6'h11, 0);
    @(negedge clk);
    checks++; if (per_r_valid_o !== BYP) begin errors++; $display("FAIL buf_valid_b0: got %b exp %b", per_r_valid_o, BYP); end
    adv();
    set_in(0, 1, 2'b11, 4'd2, 6'h22, 0);
    @(negedge clk);
    checks++; if (axi_b_ready_o !== 1'b1) begin errors++; $display("FAIL buf_b_ready_b1: got %b exp 1", axi_b_ready_o); end
    adv();
    set_in(0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    checks++; if (axi_b_ready_o !== 1'b0) begin errors++; $display("FAIL buf_b_ready_full: got %b exp 0", axi_b_ready_o); end
    e = {1'b1, 4'd1, 6'h11};
    checks++; if ({per_r_valid_o, per_r_opc_o, per_r_id_o, per_r_user_o} !== {1'b1, e}) begin errors++; $display("FAIL buf_hold: got %h exp %h", {per_r_valid_o, per_r_opc_o, per_r_id_o, per_r_user_o}, {1'b1, e}); end
    adv();
    per_r_ready_i = 1'b1;
    @(negedge clk);
    checks++; if ({per_r_valid_o, per_r_opc_o, per_r_id_o, per_r_user_o} !== {1'b1, e}) begin errors++; $display("FAIL buf_first: got %h exp %h", {per_r_valid_o, per_r_opc_o, per_r_id_o, per_r_user_o}, {1'b1, e}); end
    adv();
    e = {1'b1, 4'd2, 6'h22};
    @(negedge clk);
    checks++; if ({per_r_valid_o, per_r_opc_o, per_r_id_o, per_r_user_o} !== {1'b1, e}) begin errors++; $display("FAIL buf_second: got %h exp %h", {per_r_valid_o, per_r_opc_o, per_r_id_o, per_r_user_o}, {1'b1, e}); end
    adv();
    per_r_ready_i = 1'b0;
    @(negedge clk);
    checks++; if (per_r_valid_o !== 1'b0) begin errors++; $display("FAIL buf_drained: got %b exp 0", per_r_valid_o); end
    adv();
  endtask

  task automatic test_unexpected();
    set_in(0, 1, 2'b00, 4'd3, 6'h33, 1);
    @(negedge clk);
    checks++; if (axi_b_ready_o !== 1'b1) begin errors++; $display("FAIL unexp_b_ready: got %b exp 1", axi_b_ready_o); end
    checks++; if (per_r_valid_o !== 1'b0) begin errors++; $display("FAIL unexp_valid_c0: got %b exp 0", per_r_valid_o); end
    checks++; if (err_unexpected_o !== 1'b0) begin errors++; $display("FAIL unexp_err_before: got %b exp 0", err_unexpected_o); end
    adv();
    set_in(0, 0, 2'b00, 0, 0, 1);
    @(negedge clk);
    checks++; if (err_unexpected_o !== 1'b1) begin errors++; $display("FAIL unexp_err_set: got %b exp 1", err_unexpected_o); end
    checks++; if (per_r_valid_o !== 1'b0) begin errors++; $display("FAIL unexp_no_ack: got %b exp 0", per_r_valid_o); end
    adv(); adv(); adv();
    @(negedge clk);
    checks++; if (err_unexpected_o !== 1'b1) begin errors++; $display("FAIL unexp_err_sticky: got %b exp 1", err_unexpected_o); end
    adv();
  endtask

  task automatic test_full();
    set_in(1, 0, 2'b00, 0, 0, 1);
    repeat (7) adv();
    @(negedge clk);
    checks++; if (outstanding_full_o !== 1'b0) begin errors++; $display("FAIL full_at7: got %b exp 0", outstanding_full_o); end
    adv();
    set_in(0, 0, 2'b00, 0, 0, 1);
    @(negedge clk);
    checks++; if (outstanding_full_o !== 1'b1) begin errors++; $display("FAIL full_at8: got %b exp 1", outstanding_full_o); end
    adv();
    set_in(1, 1, 2'b01, 4'd7, 6'h07, 1);
    @(negedge clk);
    checks++; if (per_r_valid_o !== BYP) begin errors++; $display("FAIL full_same_valid: got %b exp %b", per_r_valid_o, BYP); end
    adv();
    set_in(0, 0, 2'b00, 0, 0, 1);
    @(negedge clk);
    checks++; if (outstanding_full_o !== 1'b1) begin errors++; $display("FAIL full_same_cycle: got %b exp 1", outstanding_full_o); end
    checks++; if (per_r_valid_o !== !BYP) begin errors++; $display("FAIL full_ack_valid: got %b exp %b", per_r_valid_o, !BYP); end
    adv();
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    int nr = 0;
    bit rdy = 1'b0;
    bit done = 1'b0;
    logic hs;
    for (int c = 0; c < 200; c++) begin
      set_in(0, (nb < 10), 2'b00, IDW'(nb), UW'(nb), rdy);
      @(negedge clk);
      if (!rdy && nb == 2) begin
        checks++; if (axi_b_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b exp 0", axi_b_ready_o); end
        rdy = 1'b1;
      end
      hs = axi_b_valid_i && axi_b_ready_o;
      if (per_r_valid_o && per_r_ready_i) begin
        checks++; if ({per_r_opc_o, per_r_id_o, per_r_user_o} !== {1'b0, IDW'(nr), UW'(nr)}) begin errors++; $display("FAIL b2b_order[%0d]: got %h exp %h", nr, {per_r_opc_o, per_r_id_o, per_r_user_o}, {1'b0, IDW'(nr), UW'(nr)}); end
        nr++;
      end
      aw_issued_i = hs;
      adv();
      if (hs) nb++;
      if (nr == 10) begin
        done = 1'b1;
        break;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: got %0d acks exp 10", nr); end
    set_in(0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    checks++; if (outstanding_full_o !== 1'b1) begin errors++; $display("FAIL b2b_full_kept: got %b exp 1", outstanding_full_o); end
    adv();
  endtask

  task automatic test_reset_mid();
    set_in(0, 1, 2'b10, 4'hA, 6'h0A, 0);
    adv();
    set_in(0, 1, 2'b10, 4'hB, 6'h0B, 0);
    adv();
    set_in(0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    checks++; if ({per_r_valid_o, axi_b_ready_o, per_r_id_o} !== {1'b1, 1'b0, 4'hA}) begin errors++; $display("FAIL mid_setup: got %h exp %h", {per_r_valid_o, axi_b_ready_o, per_r_id_o}, {1'b1, 1'b0, 4'hA}); end
    adv();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (per_r_valid_o !== 1'b0) begin errors++; $display("FAIL mid_in_reset: got %b exp 0", per_r_valid_o); end
    adv();
    rst_n = 1'b1;
    per_r_ready_i = 1'b1;
    @(negedge clk);
    checks++; if ({per_r_valid_o, axi_b_ready_o, outstanding_full_o, err_unexpected_o} !== 4'b0100) begin errors++; $display("FAIL mid_after: got %b exp 0100", {per_r_valid_o, axi_b_ready_o, outstanding_full_o, err_unexpected_o}); end
    adv();
    set_in(0, 1, 2'b00, 4'hC, 6'h0C, 1);
    adv();
    set_in(0, 0, 2'b00, 0, 0, 1);
    @(negedge clk);
    checks++; if ({per_r_valid_o, err_unexpected_o} !== 2'b01) begin errors++; $display("FAIL mid_count_cleared: got %b exp 01", {per_r_valid_o, err_unexpected_o}); end
    adv();
  endtask

  task automatic test_random();
    logic [14:0] e;
    bit pred;
    rst_n = 1'b0;
    set_in(0, 0, 2'b00, 0, 0, 0);
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < 500; c++) begin
      rst_n         = ($urandom_range(63) != 0);
      axi_b_valid_i = ($urandom_range(3) != 0);
      axi_b_resp_i  = 2'($urandom);
      axi_b_id_i    = IDW'($urandom);
      axi_b_user_i  = UW'($urandom);
      per_r_ready_i = ($urandom_range(3) != 0);
      pred = rst_n && axi_b_valid_i && (mq.size() < int'(DEPTH)) && (mcnt > 0);
      aw_issued_i = ($urandom_range(1) == 1) && ((mcnt < MAXO) || pred);
      @(negedge clk);
      e = exp_out();
      checks++;
      if ({per_r_valid_o, axi_b_ready_o, outstanding_full_o, err_unexpected_o,
           per_r_opc_o, per_r_id_o, per_r_user_o} !== e) begin
        errors++;
        $display("FAIL rand[%0d]: got %h exp %h", c,
                 {per_r_valid_o, axi_b_ready_o, outstanding_full_o, err_unexpected_o,
                  per_r_opc_o, per_r_id_o, per_r_user_o}, e);
      end
      adv();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_buffered();
    test_unexpected();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
